addn_and_clip_pipe: RTL

//  Parametrised successor to the two-input add-and-clip register. Sums NUM_IN signed

---
 rtl/add_clip_pkg.sv | 28 ++
 rtl/add_clip_tree_stage.sv | 59 +++++
 rtl/addn_and_clip_pipe.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/add_clip_pkg.sv
// Width arithmetic and saturation limits shared by the add-and-clip family of blocks.
package add_clip_pkg;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    function automatic longint sat_max(input int w);
        return (64'sd1 <<< (w - 1)) - 64'sd1;
    endfunction

    function automatic longint sat_min(input int w);
        return -(64'sd1 <<< (w - 1));
    endfunction

    function automatic int sum_w(input int width, input int n);
        return width + clog2(n);
    endfunction

    // Lane count remaining after `level` pairwise halvings; odd counts round up.
    function automatic int lanes_at(input int n, input int level);
        return (n + (1 << level) - 1) >> level;
    endfunction

endpackage

// File: rtl/add_clip_tree_stage.sv
// One registered adder-tree level: M signed lanes of width W reduce pairwise to
// ceil(M/2) lanes of width W+1, with valid/last carried alongside under the adv enable.
module add_clip_tree_stage
    import add_clip_pkg::*;
#(
    parameter int W = 16,
    parameter int M = 4
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 adv_i,
    input  logic [M*W-1:0]                       lanes_i,
    input  logic                                 vld_i,
    input  logic                                 last_i,
    output logic [lanes_at(M, 1)*(W+1)-1:0]      lanes_o,
    output logic                                 vld_o,
    output logic                                 last_o
);

    localparam int MO = lanes_at(M, 1);

    logic [MO*(W+1)-1:0] sum_d;
    logic [MO*(W+1)-1:0] sum_q;
    logic                last_q;
    logic                vld_q;

    for (genvar k = 0; k < MO; k++) begin : g_pair
        logic signed [W:0] a_ext;
        logic signed [W:0] b_ext;
        assign a_ext = {lanes_i[2*k*W+W-1], lanes_i[2*k*W +: W]};
        // An odd trailing lane is paired with zero.
        if (2*k + 1 < M) begin : g_b
            assign b_ext = {lanes_i[(2*k+1)*W+W-1], lanes_i[(2*k+1)*W +: W]};
        end else begin : g_pad
            assign b_ext = '0;
        end
        assign sum_d[k*(W+1) +: W+1] = a_ext + b_ext;
    end

    always_ff @(posedge clk) begin
        if (adv_i) begin
            sum_q  <= sum_d;
            last_q <= last_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= 1'b0;
        end else if (adv_i) begin
            vld_q <= vld_i;
        end
    end

    assign lanes_o = sum_q;
    assign vld_o   = vld_q;
    assign last_o  = last_q;

endmodule

// File: rtl/addn_and_clip_pipe.sv
// Sums NUM_IN signed lanes through a registered adder tree, saturates to OUT_WIDTH, and
// streams with valid/ready backpressure. Define ADDN_CLIP_STATS_EN to add clip_count.
module addn_and_clip_pipe
    import add_clip_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int NUM_IN    = 4,
    parameter int OUT_WIDTH = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic                    in_last,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [OUT_WIDTH-1:0]    out_data,
    output logic                    out_clip,
    output logic                    out_last,
    output logic                    out_valid,
    input  logic                    out_ready
`ifdef ADDN_CLIP_STATS_EN
    ,
    input  logic                    stats_clr,
    output logic [31:0]             clip_count
`endif
);

    localparam int LEVELS = clog2(NUM_IN);
    localparam int SUM_W  = sum_w(WIDTH, NUM_IN);

    localparam logic signed [SUM_W-1:0] MAX_S = SUM_W'(sat_max(OUT_WIDTH));
    localparam logic signed [SUM_W-1:0] MIN_S = SUM_W'(sat_min(OUT_WIDTH));
    localparam logic [OUT_WIDTH-1:0]    MAX_O = OUT_WIDTH'(sat_max(OUT_WIDTH));
    localparam logic [OUT_WIDTH-1:0]    MIN_O = OUT_WIDTH'(sat_min(OUT_WIDTH));

    // Returns {clip, saturated value}; the exact limits themselves are not clips.
    function automatic logic [OUT_WIDTH:0] clip_sum(input logic signed [SUM_W-1:0] s);
        if (s > MAX_S) return {1'b1, MAX_O};
        if (s < MIN_S) return {1'b1, MIN_O};
        return {1'b0, s[OUT_WIDTH-1:0]};
    endfunction

    logic                 adv;
    logic                 out_valid_q;
    logic [OUT_WIDTH-1:0] out_data_q;
    logic                 out_clip_q;
    logic                 out_last_q;

    // The whole pipe moves as one; bubbles are kept, so a stall freezes every stage.
    assign adv      = ~out_valid_q | out_ready;
    assign in_ready = adv;

    for (genvar l = 0; l < LEVELS; l++) begin : g_lvl
        localparam int MI = lanes_at(NUM_IN, l);
        localparam int MO = lanes_at(NUM_IN, l + 1);

        logic [MI*(WIDTH+l)-1:0]   lanes_in;
        logic                      vld_in;
        logic                      last_in;
        logic [MO*(WIDTH+l+1)-1:0] lanes_out;
        logic                      vld_out;
        logic                      last_out;

        if (l == 0) begin : g_src
            assign lanes_in = in_data;
            assign vld_in   = in_valid;
            assign last_in  = in_last;
        end else begin : g_chain
            assign lanes_in = g_lvl[l-1].lanes_out;
            assign vld_in   = g_lvl[l-1].vld_out;
            assign last_in  = g_lvl[l-1].last_out;
        end

        add_clip_tree_stage #(
            .W (WIDTH + l),
            .M (MI)
        ) u_stage (
            .clk     (clk),
            .rst_n   (rst_n),
            .adv_i   (adv),
            .lanes_i (lanes_in),
            .vld_i   (vld_in),
            .last_i  (last_in),
            .lanes_o (lanes_out),
            .vld_o   (vld_out),
            .last_o  (last_out)
        );
    end

    logic signed [SUM_W-1:0] sum_s;
    logic [OUT_WIDTH:0]      clip_d;

    assign sum_s  = g_lvl[LEVELS-1].lanes_out;
    assign clip_d = clip_sum(sum_s);

    // Clip stage: final register, also the output holding register under backpressure.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_clip_q  <= 1'b0;
            out_last_q  <= 1'b0;
        end else if (adv) begin
            out_valid_q <= g_lvl[LEVELS-1].vld_out;
            out_data_q  <= clip_d[OUT_WIDTH-1:0];
            out_clip_q  <= clip_d[OUT_WIDTH];
            out_last_q  <= g_lvl[LEVELS-1].last_out;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_clip  = out_clip_q;
    assign out_last  = out_last_q;

`ifdef ADDN_CLIP_STATS_EN
    logic [31:0] clip_count_d;
    logic [31:0] clip_count_q;

    // Counts transferred clipped beats, sticking at all-ones; clear has priority.
    always_comb begin
        clip_count_d = clip_count_q;
        if (stats_clr) begin
            clip_count_d = '0;
        end else if (out_valid_q && out_ready && out_clip_q && !(&clip_count_q)) begin
            clip_count_d = clip_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clip_count_q <= '0;
        end else begin
            clip_count_q <= clip_count_d;
        end
    end

    assign clip_count = clip_count_q;
`endif

endmodule
